mem_wb_reg: RTL and testbench

MEM/WB pipeline register of the RISC-V core, feeding the writeback 4:1 result mux. It captures the memory-stage results once per cycle and formats the raw data-memory word into the architectural load value (byte/halfword lane select plus sign/zero extension). It presents four candidate writeback values plus the 2-bit select to the mux, and supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/mem_wb_reg_load_ext.sv | 51 +++++
 rtl/mem_wb_reg.sv | 82 ++++++++
 tb/tb_mem_wb_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: writeback result-select codes and load funct3 encodings.
package riscv_pkg;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_reg_load_ext.sv
// load_ext: lane select and sign/zero extension of the raw data-memory word.
// Misalignment detection only exists when MEM_WB_MISALIGN_TRAP_EN is defined.
module load_ext
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = '0;
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: misalign = offset[0];
      F3_LW:         misalign = |offset;
      default:       misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: formats load data and presents the four writeback mux inputs.
// Optional macro MEM_WB_MISALIGN_TRAP_EN enables misaligned-load flagging and write suppression.
module mem_wb_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            m_valid,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [XLEN-1:0] m_rdata,
  input  logic [XLEN-1:0] m_pc_plus4,
  input  logic [XLEN-1:0] m_imm,
  input  logic [1:0]      m_result_src,
  input  logic [2:0]      m_funct3,
  input  logic            m_is_load,
  input  logic [4:0]      m_rd,
  input  logic            m_reg_write,
  output logic            w_valid,
  output logic [XLEN-1:0] w_alu,
  output logic [XLEN-1:0] w_load,
  output logic [XLEN-1:0] w_pc4,
  output logic [XLEN-1:0] w_imm,
  output logic [1:0]      w_result_src,
  output logic [4:0]      w_rd,
  output logic            w_reg_write,
  output logic            w_misalign
);

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic            mis;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata    (m_rdata),
    .offset   (m_alu_result[1:0]),
    .funct3   (m_funct3),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  // Only a real load can be misaligned; the raw detector ignores m_is_load.
  assign mis = ld_mis & m_is_load & m_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid      <= 1'b0;
      w_alu        <= '0;
      w_load       <= '0;
      w_pc4        <= '0;
      w_imm        <= '0;
      w_result_src <= RS_ALU;
      w_rd         <= '0;
      w_reg_write  <= 1'b0;
      w_misalign   <= 1'b0;
    end else if (flush) begin
      w_valid      <= 1'b0;
      w_alu        <= '0;
      w_load       <= '0;
      w_pc4        <= '0;
      w_imm        <= '0;
      w_result_src <= RS_ALU;
      w_rd         <= '0;
      w_reg_write  <= 1'b0;
      w_misalign   <= 1'b0;
    end else if (!stall) begin
      w_valid      <= m_valid;
      w_alu        <= m_alu_result;
      w_load       <= ld_data;
      w_pc4        <= m_pc_plus4;
      w_imm        <= m_imm;
      w_result_src <= m_result_src;
      w_rd         <= m_rd;
      w_reg_write  <= m_reg_write & m_valid & ~mis;
      w_misalign   <= mis;
    end
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: vector table through a scoreboard plus reset/stall/flush/misalign sequences.
module tb_mem_wb_reg;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic        is_load;
    logic [4:0]  rd;
    logic        rw;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } out_t;

  typedef struct packed {
    in_t         i;
    logic [31:0] eload;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid, m_is_load, m_reg_write;
  logic [31:0] m_alu_result, m_rdata, m_pc_plus4, m_imm;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd;
  logic        w_valid, w_reg_write, w_misalign;
  logic [31:0] w_alu, w_load, w_pc4, w_imm;
  logic [1:0]  w_result_src;
  logic [4:0]  w_rd;

  int unsigned checks = 0;
  int unsigned failures = 0;
  out_t        model;
  out_t        sbq[$];
  string       nmq[$];
  vec_t        vecs[12];

  always #5 clk = ~clk;

  mem_wb_reg #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_alu_result(m_alu_result), .m_rdata(m_rdata),
    .m_pc_plus4(m_pc_plus4), .m_imm(m_imm), .m_result_src(m_result_src),
    .m_funct3(m_funct3), .m_is_load(m_is_load), .m_rd(m_rd),
    .m_reg_write(m_reg_write), .w_valid(w_valid), .w_alu(w_alu),
    .w_load(w_load), .w_pc4(w_pc4), .w_imm(w_imm),
    .w_result_src(w_result_src), .w_rd(w_rd), .w_reg_write(w_reg_write),
    .w_misalign(w_misalign)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input out_t e);
    cmp({nm, ".valid"}, {31'd0, w_valid}, {31'd0, e.valid});
    cmp({nm, ".alu"}, w_alu, e.alu);
    cmp({nm, ".load"}, w_load, e.load);
    cmp({nm, ".pc4"}, w_pc4, e.pc4);
    cmp({nm, ".imm"}, w_imm, e.imm);
    cmp({nm, ".rs"}, {30'd0, w_result_src}, {30'd0, e.rs});
    cmp({nm, ".rd"}, {27'd0, w_rd}, {27'd0, e.rd});
    cmp({nm, ".rw"}, {31'd0, w_reg_write}, {31'd0, e.rw});
    cmp({nm, ".mis"}, {31'd0, w_misalign}, {31'd0, e.mis});
  endtask

  task automatic apply(input in_t v);
    stall = v.stall; flush = v.flush; m_valid = v.valid;
    m_alu_result = v.alu; m_rdata = v.rdata; m_pc_plus4 = v.pc4; m_imm = v.imm;
    m_result_src = v.rs; m_funct3 = v.f3; m_is_load = v.is_load;
    m_rd = v.rd; m_reg_write = v.rw;
  endtask

  // Drive one cycle, push the expected register contents, then pop and compare after the edge.
  task automatic step(input string nm, input in_t v, input logic [31:0] eload, input logic emis);
    out_t e;
    out_t got;
    string gn;
    @(negedge clk);
    apply(v);
    if (v.flush) e = '0;
    else if (v.stall) e = model;
    else begin
      e.valid = v.valid; e.alu = v.alu; e.load = eload; e.pc4 = v.pc4;
      e.imm = v.imm; e.rs = v.rs; e.rd = v.rd; e.mis = emis;
      e.rw = v.rw & v.valid & ~emis;
    end
    model = e;
    sbq.push_back(e);
    nmq.push_back(nm);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    gn = nmq.pop_front();
    check_all(gn, got);
  endtask

  function automatic in_t mk(input logic [31:0] alu, input logic [31:0] rdata,
                             input logic [2:0] f3, input logic [1:0] rs, input logic [4:0] rd);
    in_t v;
    v = '0;
    v.valid = 1'b1; v.alu = alu; v.rdata = rdata; v.f3 = f3; v.rs = rs;
    v.rd = rd; v.rw = 1'b1; v.is_load = (rs == 2'b01);
    v.pc4 = alu + 32'd4; v.imm = {rd, 27'h5A5A5A5};
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t v;
    reset = 1'b1;
    apply('0);
    model = '0;

    vecs[0]  = '{mk(32'h0000_1003, 32'h80FF_7F01, 3'b000, 2'b01, 5'd1), 32'hFFFF_FF80};
    vecs[1]  = '{mk(32'h0000_1003, 32'h80FF_7F01, 3'b100, 2'b01, 5'd2), 32'h0000_0080};
    vecs[2]  = '{mk(32'h0000_1002, 32'h8001_1234, 3'b001, 2'b01, 5'd3), 32'hFFFF_8001};
    vecs[3]  = '{mk(32'h0000_1000, 32'h8001_1234, 3'b001, 2'b01, 5'd4), 32'h0000_1234};
    vecs[4]  = '{mk(32'h0000_1002, 32'h8001_1234, 3'b101, 2'b01, 5'd6), 32'h0000_8001};
    vecs[5]  = '{mk(32'h0000_2000, 32'h80FF_7F01, 3'b000, 2'b01, 5'd7), 32'h0000_0001};
    vecs[6]  = '{mk(32'h0000_2001, 32'h80FF_7F01, 3'b000, 2'b01, 5'd8), 32'h0000_007F};
    vecs[7]  = '{mk(32'h0000_2002, 32'h80FF_7F01, 3'b000, 2'b01, 5'd9), 32'hFFFF_FFFF};
    vecs[8]  = '{mk(32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 2'b01, 5'd10), 32'hDEAD_BEEF};
    vecs[9]  = '{mk(32'h0000_2000, 32'hCAFE_F00D, 3'b011, 2'b01, 5'd11), 32'hCAFE_F00D};
    vecs[10] = '{mk(32'h0000_0000, 32'h1357_9BDF, 3'b010, 2'b10, 5'd12), 32'h1357_9BDF};
    vecs[10].i.pc4 = 32'h0000_0104;
    vecs[10].i.imm = 32'hABCD_E000;
    vecs[11] = '{mk(32'h0000_3004, 32'h0000_8000, 3'b101, 2'b01, 5'd13), 32'h0000_8000};
    vecs[11].i.valid = 1'b0;

    #12;
    check_all("reset_init", '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      step($sformatf("vec%0d", i), vecs[i].i, vecs[i].eload, 1'b0);

    // Stall: capture rd=5, then hold for three cycles while inputs change.
    v = mk(32'h0000_4000, 32'h1111_2222, 3'b010, 2'b00, 5'd5);
    step("cap_rd5", v, 32'h1111_2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      v = mk(32'h0000_5000 + i, 32'h9999_0000 + i, 3'b000, 2'b11, 5'd20 + 5'(i));
      v.stall = 1'b1;
      v.rw = 1'b0;
      step($sformatf("stall%0d", i), v, 32'h0, 1'b0);
    end
    cmp("stall_rd5", {27'd0, w_rd}, 32'd5);
    v = mk(32'h0000_6000, 32'h7777_7777, 3'b010, 2'b01, 5'd9);
    v.stall = 1'b1;
    v.flush = 1'b1;
    step("stall_flush", v, 32'h0, 1'b0);

    // Misaligned LW and LH: flagged and write-suppressed only with the trap feature.
    v = mk(32'h0000_1002, 32'h0BAD_F00D, 3'b010, 2'b01, 5'd14);
    step("lw_mis", v, 32'h0BAD_F00D, TRAP);
    v = mk(32'h0000_1001, 32'h8765_C321, 3'b001, 2'b01, 5'd15);
    step("lh_mis", v, 32'hFFFF_C321, TRAP);
    v = mk(32'h0000_1001, 32'h8765_C321, 3'b001, 2'b01, 5'd16);
    v.valid = 1'b0;
    step("lh_mis_inval", v, 32'hFFFF_C321, 1'b0);
    v = mk(32'h0000_1003, 32'h0BAD_F00D, 3'b010, 2'b00, 5'd17);
    v.is_load = 1'b0;
    step("lw_notload", v, 32'h0BAD_F00D, 1'b0);

    // Reset asserted mid-cycle during a stall clears at once and holds across the edge.
    v = mk(32'h0000_7000, 32'hFEDC_BA98, 3'b010, 2'b01, 5'd21);
    step("pre_reset", v, 32'hFEDC_BA98, 1'b0);
    @(negedge clk);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_all("reset_async", '0);
    @(posedge clk);
    #1;
    check_all("reset_hold", '0);
    @(negedge clk);
    reset = 1'b0;
    model = '0;
    v = mk(32'h0000_8000, 32'h2468_ACE0, 3'b010, 2'b01, 5'd22);
    v.stall = 1'b1;
    step("post_reset_stall", v, 32'h0, 1'b0);
    v.stall = 1'b0;
    step("post_reset_cap", v, 32'h2468_ACE0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
